// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch stage: owns the PC, absorbs the one-cycle registered imem
// read latency and feeds the IF/ID register through a one-entry stall skid buffer.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4
);

  logic [31:0] pc_r, pc_s;
  logic        req_valid_r, req_valid_s;
  logic [31:0] req_pc_r, req_pc_s;
  logic        skid_valid_r, skid_valid_s;
  logic [31:0] skid_instr_r, skid_instr_s;
  logic [31:0] skid_pc_r, skid_pc_s;
  logic        ifid_valid_r, ifid_valid_s;
  logic [31:0] ifid_instr_r, ifid_instr_s;
  logic [31:0] ifid_pc_r, ifid_pc_s;
  logic [31:0] ifid_pc4_r, ifid_pc4_s;

  // Next-state selection: redirect beats stall, stall beats advance.
  always_comb begin
    pc_s         = pc_r;
    req_valid_s  = req_valid_r;
    req_pc_s     = req_pc_r;
    skid_valid_s = skid_valid_r;
    skid_instr_s = skid_instr_r;
    skid_pc_s    = skid_pc_r;
    ifid_valid_s = ifid_valid_r;
    ifid_instr_s = ifid_instr_r;
    ifid_pc_s    = ifid_pc_r;
    ifid_pc4_s   = ifid_pc4_r;
    if (redirect_valid) begin
      // In-flight fetch and skid are both stale once the target changes.
      pc_s         = redirect_pc & ~32'd3;
      req_valid_s  = 1'b0;
      skid_valid_s = 1'b0;
      ifid_valid_s = 1'b0;
      ifid_instr_s = 32'h0000_0000;
    end else if (stall) begin
      req_valid_s = 1'b0;
      if (req_valid_r) begin
        skid_valid_s = 1'b1;
        skid_instr_s = imem_rdata;
        skid_pc_s    = req_pc_r;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end else begin
      if (skid_valid_r) begin
        ifid_valid_s = 1'b1;
        ifid_instr_s = skid_instr_r;
        ifid_pc_s    = skid_pc_r;
      end else begin
        ifid_valid_s = req_valid_r;
        ifid_instr_s = req_valid_r ? imem_rdata : 32'h0000_0000;
        ifid_pc_s    = req_pc_r;
      end
      ifid_pc4_s   = ifid_pc_s + 32'd4;
      skid_valid_s = 1'b0;
      req_valid_s  = 1'b1;
      req_pc_s     = pc_r;
      pc_s         = pc_r + 32'd4;
    end
  end

  // Pipeline state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r         <= RESET_PC;
      req_valid_r  <= 1'b0;
      req_pc_r     <= 32'h0000_0000;
      skid_valid_r <= 1'b0;
      skid_instr_r <= 32'h0000_0000;
      skid_pc_r    <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
      ifid_instr_r <= 32'h0000_0000;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_pc4_r   <= 32'h0000_0004;
    end else begin
      pc_r         <= pc_s;
      req_valid_r  <= req_valid_s;
      req_pc_r     <= req_pc_s;
      skid_valid_r <= skid_valid_s;
      skid_instr_r <= skid_instr_s;
      skid_pc_r    <= skid_pc_s;
      ifid_valid_r <= ifid_valid_s;
      ifid_instr_r <= ifid_instr_s;
      ifid_pc_r    <= ifid_pc_s;
      ifid_pc4_r   <= ifid_pc4_s;
    end
  end

  assign imem_addr      = pc_r;
  assign if_id_valid    = ifid_valid_r;
  assign if_id_instr    = ifid_instr_r;
  assign if_id_pc       = ifid_pc_r;
  assign if_id_pc_plus4 = ifid_pc4_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected IF/ID contents are queued
// per advancing edge and compared as the DUT delivers them.
module tb_instruction_fetch_unit;

  typedef struct {
    logic        v;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n, rst1_n;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
  logic [31:0] imem_addr1, imem_rdata1;
  logic        if_id_valid1;
  logic [31:0] if_id_instr1, if_id_pc1, if_id_pc_plus41;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t last0;
  logic pc_known;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst1_n), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0000_0000), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
    .if_id_valid(if_id_valid1), .if_id_instr(if_id_instr1), .if_id_pc(if_id_pc1),
    .if_id_pc_plus4(if_id_pc_plus41)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata  <= mem_word(imem_addr);
    imem_rdata1 <= mem_word(imem_addr1);
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic exp_word(input logic [31:0] pc);
    exp_t e;
    e.v = 1'b1;
    e.pc = pc;
    q0.push_back(e);
  endtask

  task automatic exp_nop();
    exp_t e;
    e.v = 1'b0;
    e.pc = 32'h0;
    q0.push_back(e);
  endtask

  task automatic exp_wrap(input logic v, input logic [31:0] pc);
    exp_t e;
    e.v = v;
    e.pc = pc;
    q1.push_back(e);
  endtask

  task automatic cmp_ifid(input string tag, input exp_t e, input logic vld,
                          input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4);
    check32({tag, ".valid"}, {31'd0, vld}, {31'd0, e.v});
    check32({tag, ".instr"}, ins, e.v ? mem_word(e.pc) : 32'h0);
    if (e.v) begin
      check32({tag, ".pc"}, pc, e.pc);
      check32({tag, ".pc4"}, pc4, e.pc + 32'd4);
    end
  endtask

  task automatic adv(input string tag);
    exp_t e;
    stall = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    if (q0.size() == 0) begin
      check32({tag, ".underflow"}, 32'd1, 32'd0);
    end else begin
      e = q0.pop_front();
      cmp_ifid(tag, e, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4);
      last0 = e;
      pc_known = e.v;
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp_ifid({tag, ".wrap"}, e, if_id_valid1, if_id_instr1, if_id_pc1, if_id_pc_plus41);
    end
  endtask

  task automatic stall_step(input string tag, input logic [31:0] addr);
    stall = 1'b1;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    check32({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, last0.v});
    check32({tag, ".instr"}, if_id_instr, last0.v ? mem_word(last0.pc) : 32'h0);
    if (pc_known) check32({tag, ".pc"}, if_id_pc, last0.pc);
    check32({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic redirect_step(input string tag, input logic [31:0] tgt, input logic st);
    stall = st;
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    @(posedge clk);
    #1;
    check32({tag, ".valid"}, {31'd0, if_id_valid}, 32'd0);
    check32({tag, ".instr"}, if_id_instr, 32'h0);
    if (pc_known) check32({tag, ".pc_hold"}, if_id_pc, last0.pc);
    check32({tag, ".addr"}, imem_addr, tgt & ~32'd3);
    last0.v = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset0(input string tag);
    check32({tag, ".valid"}, {31'd0, if_id_valid}, 32'd0);
    check32({tag, ".instr"}, if_id_instr, 32'h0);
    check32({tag, ".pc"}, if_id_pc, 32'h0);
    check32({tag, ".pc4"}, if_id_pc_plus4, 32'h4);
    check32({tag, ".addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    rst1_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    pc_known = 1'b0;
    last0.v = 1'b0;
    last0.pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset0("rst");
    check32("rst_wrap.addr", imem_addr1, 32'hFFFF_FFF8);
    check32("rst_wrap.pc4", if_id_pc_plus41, 32'h4);

    // Free run on both instances, including the PC wrap on the second.
    rst_n = 1'b1;
    rst1_n = 1'b1;
    exp_nop(); exp_word(32'h0); exp_word(32'h4); exp_word(32'h8); exp_word(32'hC);
    exp_wrap(1'b0, 32'h0); exp_wrap(1'b1, 32'hFFFF_FFF8); exp_wrap(1'b1, 32'hFFFF_FFFC);
    exp_wrap(1'b1, 32'h0); exp_wrap(1'b1, 32'h4);
    for (int i = 0; i < 5; i++) adv("run");
    rst1_n = 1'b0;

    // Stall with B in flight, then redirect from C.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_nop(); exp_word(32'h0);
    adv("s_boot"); adv("s_a");
    for (int i = 0; i < 3; i++) stall_step("stall3", 32'h8);
    exp_word(32'h4); exp_word(32'h8);
    adv("s_b"); adv("s_c");
    redirect_step("redir", 32'h0000_002C, 1'b0);
    exp_nop(); exp_word(32'h2C); exp_word(32'h30);
    adv("r_bub"); adv("r_t0"); adv("r_t1");

    // Redirect while stalled with a full skid.
    stall_step("skid_fill", 32'h38);
    redirect_step("redir_st", 32'h0000_0083, 1'b1);
    exp_nop(); exp_word(32'h80); exp_word(32'h84);
    adv("rs_bub"); adv("rs_t0"); adv("rs_t1");

    // Asynchronous reset in the middle of a stall.
    stall_step("pre_rst", 32'h8C);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset0("arst");
    stall = 1'b0;
    @(posedge clk);
    #1;
    check_reset0("arst_hold");
    rst_n = 1'b1;
    exp_nop(); exp_word(32'h0); exp_word(32'h4);
    adv("ar_bub"); adv("ar_0"); adv("ar_4");

    check32("queue_empty", q0.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter and drives word addresses to the instruction memory. It absorbs that memory's one-cycle registered read latency and delivers instructions into the IF/ID pipeline register. Hazard-unit stalls are handled with a one-entry skid buffer, so no fetched word is lost and no duplicate is issued. Branch redirects from EX flush the IF/ID register and any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset (word aligned)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: hold IF/ID and PC this cycle
- redirect_valid  in  1  taken branch/jump resolved; overrides stall
- redirect_pc  in  32  new fetch target; bits [1:0] forced to 0
- imem_addr  out  32  byte address to instruction memory (= PC register)
- imem_rdata  in  32  word for address sampled at the previous rising edge
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  32  instruction; 32'h0000_0000 (NOP) whenever invalid
- if_id_pc  out  32  address of if_id_instr
- if_id_pc_plus4  out  32  if_id_pc + 4, modulo 2^32

## Operation
- State: pc, req_valid/req_pc (fetch in flight), skid_valid/skid_instr/skid_pc, IF/ID outputs.
- Invariant: skid_valid and req_valid are never both 1.
- Per rising edge, in strict priority:
  - **Reset** (rst_n=0, async):
    - pc=RESET_PC; req_valid=0; skid_valid=0.
    - if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=4.
  - **Redirect**:
    - pc<=redirect_pc & ~3; req_valid<=0; skid_valid<=0.
    - if_id_valid<=0, if_id_instr<=0; if_id_pc fields hold.
    - Applies regardless of stall.
  - **Stall** (no redirect):
    - IF/ID holds; pc holds; req_valid<=0 (no new issue).
    - If req_valid=1: skid captures {imem_rdata, req_pc}, skid_valid<=1.
  - **Advance** (no stall, no redirect):
    - IF/ID loads skid if skid_valid, else {imem_rdata, req_pc}.
    - if_id_valid<=skid_valid|req_valid; invalid loads write instr=0.
    - skid_valid<=0; req_valid<=1; req_pc<=pc; pc<=pc+4.
- PC increment wraps 32'hFFFF_FFFC -> 0. No other arithmetic.
- Memory reads during stall/redirect cycles are ignored; the address bus may still toggle.

## Timing
- Fetch latency: address issued at edge E, instruction valid in IF/ID after edge E+1.
- After reset release:
  - 1st edge issues RESET_PC.
  - 2nd edge: IF/ID = {mem[RESET_PC>>2], RESET_PC}, valid.
  - Then one instruction per cycle.
- Stall of N cycles (N>=1) costs exactly N cycles, no bubble:
  - The release edge delivers the skid word.
  - The next edge delivers the word at the held pc.
- Redirect penalty:
  - Redirect edge: IF/ID=NOP.
  - Next edge: IF/ID=NOP (the in-flight fetch was killed).
  - Following edge: target instruction.
- Redirect and stall in the same cycle: redirect wins; the skid is cleared.
- Asynchronous reset mid-stall or mid-redirect: all state cleared immediately; outputs at reset values until the first edge after rst_n rises.
- Outputs are purely registered. imem_addr is the pc register, with no combinational path from inputs.

## Test plan
- Reset, then free-run with mem[0..3]=A,B,C,D -> IF/ID shows A@0, B@4, C@8, D@12 on consecutive edges starting at the 2nd edge after release; pc_plus4 = 4, 8, 12, 16.
- Stall for 3 cycles while B is in flight -> IF/ID holds A for 3 cycles, then B@4, then C@8; no duplicate, no gap; imem_addr frozen at 8 during stall.
- Redirect to 32'h0000_002C when IF/ID=C@8 -> two NOP cycles (valid=0, instr=0), then mem[11]@0x2C, then mem[12]@0x30.
- Redirect asserted together with stall and skid full -> skid discarded; target appears 2 edges later; no stale word escapes.
- RESET_PC=32'hFFFF_FFF8 -> fetches at FFF8, FFFC, then 0; if_id_pc_plus4 for FFFC is 0.
- Assert rst_n low asynchronously mid-stall -> if_id_valid drops to 0 and imem_addr=RESET_PC before the next clock edge.
